// File: rtl/show_result.sv
// Converts a 32-bit result to four BCD digits and multiplexes them onto a
// four-digit seven-segment display.
// Ports: clk, rst (sync, active-high); value/load in; busy/done/overflow/bcd
// status out; seg (active-low, g..a) and an (active-low, an[0]=units) drive
// the display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module show_result #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   adj;
  logic [15:0]   shifted;

  // add-3 correction on every nibble before the shift
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[14:0], bin_q[13]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CONV;
          bin_d   = value[13:0];
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = (value > 32'd9999);
        end
      end
      CONV: begin
        acc_d = shifted;
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = FIN;
          bcd_d   = ovf_q ? 16'hFFFF : shifted;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + CW'(1);
    idx_d  = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = (state_q == FIN);
  assign overflow = ovf_q;
  assign bcd      = bcd_q;

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    nib   = 4'h0;
    an    = 4'b1111;
    blank = 1'b0;
    unique case (idx_q)
      2'd0: begin nib = bcd_q[3:0];   an = 4'b1110; end
      2'd1: begin nib = bcd_q[7:4];   an = 4'b1101; end
      2'd2: begin nib = bcd_q[11:8];  an = 4'b1011; end
      2'd3: begin nib = bcd_q[15:12]; an = 4'b0111; end
      default: begin nib = 4'h0; an = 4'b1111; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // a digit is leading only if it and every digit above it are zero
    unique case (idx_q)
      2'd1: blank = (bcd_q[15:4] == 12'h000);
      2'd2: blank = (bcd_q[15:8] == 8'h00);
      2'd3: blank = (bcd_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hF: seg = 7'b0111111;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_show_result.sv
// Self-checking bench for show_result with SCAN_DIV=4: directed scenarios
// followed by random loads/resets, all compared to a cycle-level model.
module tb_show_result;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  show_result #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .bcd(bcd),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: age 0 = idle, 1..14 = converting, 15 = result cycle
  int          m_age;
  int          m_cyc;
  int unsigned m_cap;
  logic        m_ovf;
  logic [15:0] m_bcd;
  int          done_seen;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hF: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int idx);
    logic [15:0] upper;
    upper = b >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && upper == 16'h0000) return 7'b1111111;
`endif
    return digit_seg(upper[3:0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld,
                            input logic [31:0] v);
    if (r) begin
      m_age = 0; m_cyc = 0; m_ovf = 1'b0; m_bcd = 16'h0000;
    end else begin
      m_cyc++;
      if (m_age == 0) begin
        if (ld) begin
          m_age = 1; m_cap = v; m_ovf = (v > 9999);
        end
      end else if (m_age < 15) begin
        m_age++;
        if (m_age == 15) m_bcd = to_bcd(m_cap);
      end else begin
        m_age = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [31:0] v);
    int idx;
    logic [3:0] exp_an;
    rst = r; load = ld; value = v;
    @(posedge clk);
    model_edge(r, ld, v);
    @(negedge clk);
    idx = (m_cyc / 4) % 4;
    exp_an = ~(4'b0001 << idx);
    if (done === 1'b1) done_seen++;
    check("busy", 32'(busy), 32'(m_age >= 1 && m_age <= 14));
    check("done", 32'(done), 32'(m_age == 15));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("bcd", 32'(bcd), 32'(m_bcd));
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg(m_bcd, idx)));
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, value);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    m_age = 0; m_cyc = 0; m_cap = 0; m_ovf = 1'b0; m_bcd = '0;
    done_seen = 0;

    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("reset_an", 32'(an), 32'(4'b1110));
    check("reset_bcd", 32'(bcd), 32'h0);

    // 1234: done exactly 15 edges after load
    step(1'b0, 1'b1, 32'd1234);
    idle(14);
    check("d1234_done", 32'(done), 32'd1);
    check("d1234_bcd", 32'(bcd), 32'h1234);
    idle(20);

    // overflow shows dashes on every digit
    step(1'b0, 1'b1, 32'd10000);
    idle(14);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_bcd", 32'(bcd), 32'hFFFF);
    idle(20);

    // small value exercises leading digits
    step(1'b0, 1'b1, 32'd7);
    idle(32);

    // second load during conversion must be ignored
    done_seen = 0;
    step(1'b0, 1'b1, 32'd42);
    idle(4);
    step(1'b0, 1'b1, 32'd99);
    idle(20);
    check("ignore_done_cnt", 32'(done_seen), 32'd1);
    check("ignore_bcd", 32'(bcd), 32'h0042);

    // reset mid-conversion aborts it
    step(1'b0, 1'b1, 32'd9999);
    idle(6);
    done_seen = 0;
    step(1'b1, 1'b0, 32'd0);
    check("abort_an", 32'(an), 32'(4'b1110));
    idle(20);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);

    // reset wins over load
    step(1'b1, 1'b1, 32'd5555);
    idle(20);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, ld;
      logic [31:0] v;
      r  = ($urandom_range(0, 149) == 0);
      ld = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) v = $urandom;
      else v = 32'($urandom_range(0, 9999));
      step(r, ld, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/show_result.md
SHOW_RESULT -- requirements
Module: show_result

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each display digit stays lit (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port value, input, 32 bits: unsigned calculator result to display.
REQ-005 SHALL have port load, input, 1 bit: one-cycle strobe requesting conversion of value.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when new digits are valid.
REQ-008 SHALL have port overflow, output, 1 bit: the last accepted value exceeded 9999.
REQ-009 SHALL have port bcd, output, 16 bits: four BCD digits; [3:0] units, [15:12] thousands.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments, bit order g f e d c b a.
REQ-011 SHALL have port an, output, 4 bits: active-low one-hot digit enable; an[0] is units.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV and FIN.
REQ-013 In IDLE, with load=1 at edge N, SHALL capture value and go to CONV; busy SHALL be 1 from edge N+1.
REQ-014 When value > 9999 at capture, SHALL set overflow at edge N+1; otherwise SHALL clear it at edge N+1.
REQ-015 CONV SHALL run double-dabble on the low 14 bits: one shift per cycle, 14 cycles, add-3 to any nibble >= 5 before each shift.
REQ-016 At edge N+15 SHALL enter FIN, update bcd, assert done and deassert busy.
REQ-017 Latency from load to done SHALL be exactly 15 cycles, independent of value or overflow.
REQ-018 On overflow, bcd SHALL be loaded with 16'hFFFF at edge N+15.
REQ-019 FIN SHALL last one cycle and then return to IDLE; done SHALL be high only in FIN.
REQ-020 load while in CONV or FIN SHALL be ignored and SHALL NOT alter the conversion.
REQ-021 Between conversions, bcd and overflow SHALL hold their last values.
REQ-022 A free-running scan counter SHALL count 0..SCAN_DIV-1 and wrap.
REQ-023 On each wrap, the digit index SHALL advance 0,1,2,3,0; an SHALL be 1110, 1101, 1011, 0111 for indices 0 to 3.
REQ-024 seg SHALL decode the bcd nibble at the current index combinationally.
REQ-025 seg decode values: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
REQ-026 Nibble F SHALL display dash (0111111); nibbles A to E SHALL display blank (1111111).
REQ-027 Scanning SHALL continue unaffected during conversion and SHALL show the old bcd until FIN.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, overflow=0, bcd=0, scan counter=0, index=0, an=1110.
REQ-029 rst SHALL take priority over load in the same cycle.
REQ-030 rst mid-conversion SHALL abort it; bcd SHALL remain 0 and no done SHALL be produced.

Configuration
REQ-031 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL display blank (1111111) for zero thousands, hundreds or tens digits that have only zeros above them; the units digit SHALL always display.
REQ-032 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded per REQ-025/026.
REQ-033 LEADING_ZERO_BLANK_EN SHALL NOT affect bcd, busy, done, overflow or timing.

Verification (bench uses SCAN_DIV=4)
REQ-034 Reset, then load value=1234 -> done 15 cycles later, bcd=16'h1234, overflow=0, busy high for cycles 1 to 14.
REQ-035 load value=10000 -> done after 15 cycles, overflow=1, bcd=16'hFFFF, seg=0111111 on every digit.
REQ-036 value=7 with LEADING_ZERO_BLANK_EN -> seg blank on an=0111/1011/1101 and 1111000 on an=1110; without the macro -> 1000000 on the upper digits.
REQ-037 load value=42, then load=1 again 5 cycles later with value=99 -> single done, bcd=16'h0042.
REQ-038 rst asserted 7 cycles into a conversion of 9999 -> no done, bcd=0, an=1110 next cycle.
REQ-039 Idle scan -> an advances every 4 cycles through 1110, 1101, 1011, 0111 and repeats.
